// File: rtl/mole_hit_detector.sv
// mole_hit_detector: synchronizes and debounces mole buttons, arbitrates presses and reports hit/miss.
// Defining MOLE_HIT_MISS_CNT_EN adds a saturating miss_count output.
module mole_hit_detector #(
   parameter int unsigned NUM_MOLES       = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned DB_CNT_W        = 20
) (
   input  logic                         clkIn,
   input  logic                         reset,
   input  logic                         game_active,
   input  logic [NUM_MOLES-1:0]         btn,
   input  logic [NUM_MOLES-1:0]         mole_mask,
   output logic                         player_scored,
   output logic [NUM_MOLES-1:0]         mole_clear,
   output logic                         miss,
   output logic [$clog2(NUM_MOLES)-1:0] hit_idx
`ifdef MOLE_HIT_MISS_CNT_EN
   ,
   output logic [7:0]                   miss_count
`endif
);

   localparam int unsigned         IDX_W   = $clog2(NUM_MOLES);
   localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, EVAL, LOCKOUT} state_t;

   state_t               state_q, state_d;
   logic [NUM_MOLES-1:0] sync1_q, sync2_q;
   logic [NUM_MOLES-1:0] db_q, db_d, db_prev_q;
   logic [DB_CNT_W-1:0]  cnt_q [NUM_MOLES];
   logic [DB_CNT_W-1:0]  cnt_d [NUM_MOLES];
   logic [NUM_MOLES-1:0] press;
   logic                 press_any;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
   logic                 player_scored_q, player_scored_d;
   logic                 miss_q, miss_d;
   logic [NUM_MOLES-1:0] mole_clear_q, mole_clear_d;

   // Input synchronizers, debounced levels and their one-cycle-delayed copy
   always_ff @(posedge clkIn or posedge reset) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         for (int i = 0; i < int'(NUM_MOLES); i++) cnt_q[i] <= '0;
      end else begin
         sync1_q   <= btn;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         for (int i = 0; i < int'(NUM_MOLES); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // A differing level must persist DEBOUNCE_CYCLES samples before it is accepted
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < int'(NUM_MOLES); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DB_LAST) db_d[i] = sync2_q[i];
            else                     cnt_d[i] = cnt_q[i] + DB_CNT_W'(1);
         end
      end
   end

   assign press     = db_q & ~db_prev_q;
   assign press_any = |press;

   // Lowest-index press wins; scan downwards so the lowest set bit is assigned last
   always_comb begin
      win_idx = '0;
      for (int i = int'(NUM_MOLES) - 1; i >= 0; i--) begin
         if (press[i]) win_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clkIn or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (press_any) state_d = EVAL;
         EVAL:    state_d = LOCKOUT;
         LOCKOUT: if (db_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (!game_active) state_d = IDLE;
   end

   always_comb begin
      hit_idx_d       = hit_idx_q;
      player_scored_d = 1'b0;
      miss_d          = 1'b0;
      mole_clear_d    = '0;
      if (game_active) begin
         case (state_q)
            IDLE: if (press_any) hit_idx_d = win_idx;
            EVAL: begin
               if (mole_mask[hit_idx_q]) begin
                  player_scored_d = 1'b1;
                  mole_clear_d    = NUM_MOLES'(1) << hit_idx_q;
               end else begin
                  miss_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clkIn or posedge reset) begin
      if (reset) begin
         hit_idx_q       <= '0;
         player_scored_q <= 1'b0;
         miss_q          <= 1'b0;
         mole_clear_q    <= '0;
      end else begin
         hit_idx_q       <= hit_idx_d;
         player_scored_q <= player_scored_d;
         miss_q          <= miss_d;
         mole_clear_q    <= mole_clear_d;
      end
   end

   assign player_scored = player_scored_q;
   assign miss          = miss_q;
   assign mole_clear    = mole_clear_q;
   assign hit_idx       = hit_idx_q;

`ifdef MOLE_HIT_MISS_CNT_EN
   logic [7:0] miss_cnt_q, miss_cnt_d;

   // Counts alongside the miss pulse; saturates and clears outside a game
   always_comb begin
      miss_cnt_d = miss_cnt_q;
      if (!game_active)                         miss_cnt_d = '0;
      else if (miss_d && miss_cnt_q != 8'hFF)   miss_cnt_d = miss_cnt_q + 8'd1;
   end

   always_ff @(posedge clkIn or posedge reset) begin
      if (reset) miss_cnt_q <= '0;
      else       miss_cnt_q <= miss_cnt_d;
   end

   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mole_hit_detector.sv
// Scoreboard bench for mole_hit_detector: a reference model queues expected hit/miss events,
// a negedge monitor pops and checks them whenever the DUT pulses.
module tb_mole_hit_detector;

   localparam int NM  = 4;
   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        game_active = 1'b0;
   logic [3:0]  btn = '0;
   logic [3:0]  mole_mask = '0;
   logic        player_scored;
   logic [3:0]  mole_clear;
   logic        miss;
   logic [1:0]  hit_idx;
`ifdef MOLE_HIT_MISS_CNT_EN
   logic [7:0]  miss_count;
`endif

   mole_hit_detector #(.NUM_MOLES(NM), .DEBOUNCE_CYCLES(DEB), .DB_CNT_W(3)) dut (
      .clkIn(clk),
      .reset(reset),
      .game_active(game_active),
      .btn(btn),
      .mole_mask(mole_mask),
      .player_scored(player_scored),
      .mole_clear(mole_clear),
      .miss(miss),
      .hit_idx(hit_idx)
`ifdef MOLE_HIT_MISS_CNT_EN
      ,
      .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { bit hit; int idx; int mc; } exp_t;
   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_hit_seen  = 0;
   int n_miss_seen = 0;

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: button history per position, phase of the press handler
   localparam int P_IDLE = 0, P_EVAL = 1, P_LOCK = 2;
   int m_s1[NM], m_s2[NM], m_db[NM], m_run[NM];
   int m_pend, m_phase, m_idx, m_mc;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NM; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
         end
         m_pend = 0; m_phase = P_IDLE; m_idx = 0; m_mc = 0;
         exp_q.delete();
      end else begin
         int any_down;
         any_down = 0;
         for (int i = 0; i < NM; i++) if (m_db[i] != 0) any_down = 1;
         if (!game_active) begin
            m_phase = P_IDLE;
            m_mc = 0;
         end else begin
            case (m_phase)
               P_IDLE: if (m_pend != 0) begin
                  for (int i = NM - 1; i >= 0; i--) if (((m_pend >> i) & 1) != 0) m_idx = i;
                  m_phase = P_EVAL;
               end
               P_EVAL: begin
                  exp_t e;
                  e.hit = mole_mask[m_idx];
                  e.idx = m_idx;
                  if (!e.hit && m_mc < 255) m_mc++;
                  e.mc = m_mc;
                  exp_q.push_back(e);
                  m_phase = P_LOCK;
               end
               default: if (any_down == 0) m_phase = P_IDLE;
            endcase
         end
         m_pend = 0;
         for (int i = 0; i < NM; i++) begin
            if (m_s2[i] != m_db[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_db[i] = m_s2[i];
                  m_run[i] = 0;
                  if (m_db[i] != 0) m_pend = m_pend | (1 << i);
               end
            end else begin
               m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(btn[i]);
         end
      end
   end

   // Monitor: every DUT pulse must match the oldest expected event
   bit prev_pulse = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         prev_pulse = 1'b0;
      end else begin
         bit pulse;
         pulse = player_scored | miss | (|mole_clear);
         if (pulse) begin
            if (player_scored) n_hit_seen++;
            if (miss)          n_miss_seen++;
            chk("pulse_single_cycle", int'(prev_pulse), 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               exp_t e;
               logic [3:0] ec;
               e = exp_q.pop_front();
               ec = e.hit ? (4'b0001 << e.idx) : 4'b0000;
               chk("player_scored", int'(player_scored), int'(e.hit));
               chk("miss", int'(miss), int'(!e.hit));
               chk("mole_clear", int'(mole_clear), int'(ec));
               chk("hit_idx", int'(hit_idx), e.idx);
`ifdef MOLE_HIT_MISS_CNT_EN
               chk("miss_count", int'(miss_count), e.mc);
`endif
            end
         end
         prev_pulse = pulse;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   int h0, m0;
   task automatic mark();
      h0 = n_hit_seen; m0 = n_miss_seen;
   endtask

   initial begin
      cyc(3);
      chk("rst_player_scored", int'(player_scored), 0);
      chk("rst_miss", int'(miss), 0);
      chk("rst_mole_clear", int'(mole_clear), 0);
      chk("rst_hit_idx", int'(hit_idx), 0);
      reset = 1'b0;
      game_active = 1'b1;
      cyc(3);

      // Clean hit on mole 2
      mark(); mole_mask = 4'b0100; btn = 4'b0100; cyc(15); btn = 4'b0000; cyc(15);
      chk("s1_hits", n_hit_seen - h0, 1);
      chk("s1_misses", n_miss_seen - m0, 0);
      chk("s1_hit_idx_held", int'(hit_idx), 2);

      // Press at an empty position
      mark(); btn = 4'b0010; cyc(15); btn = 4'b0000; cyc(15);
      chk("s2_misses", n_miss_seen - m0, 1);
      chk("s2_hits", n_hit_seen - h0, 0);

      // Bouncing contact, then a stable hold
      mark(); mole_mask = 4'b0001;
      for (int k = 0; k < 10; k++) begin btn[0] = ~btn[0]; cyc(2); end
      chk("s3_no_hit_while_bouncing", n_hit_seen - h0, 0);
      btn = 4'b0001; cyc(15); btn = 4'b0000; cyc(15);
      chk("s3_hits", n_hit_seen - h0, 1);

      // Simultaneous presses; lockout until both released
      mark(); mole_mask = 4'b1010; btn = 4'b1010; cyc(15);
      chk("s4_hits", n_hit_seen - h0, 1);
      chk("s4_hit_idx", int'(hit_idx), 1);
      btn = 4'b1000; cyc(12); btn = 4'b1010; cyc(15);
      chk("s4_lockout", n_hit_seen + n_miss_seen - h0 - m0, 1);
      btn = 4'b0000; cyc(15);

      // Button held across game start
      mark(); mole_mask = 4'b0001; game_active = 1'b0; btn = 4'b0001; cyc(15);
      game_active = 1'b1; cyc(15);
      chk("s5_held_no_pulse", n_hit_seen + n_miss_seen - h0 - m0, 0);
      btn = 4'b0000; cyc(15); btn = 4'b0001; cyc(15); btn = 4'b0000; cyc(15);
      chk("s5_repress_hit", n_hit_seen - h0, 1);

      // Reset while in EVAL
      mark(); mole_mask = 4'b0100; btn = 4'b0100; cyc(7);
      chk("s6_idx_before_reset", int'(hit_idx), 2);
      reset = 1'b1; #1;
      chk("s6_rst_hit_idx", int'(hit_idx), 0);
      chk("s6_rst_outputs", int'({player_scored, miss, mole_clear}), 0);
      btn = 4'b0000; cyc(3); reset = 1'b0; cyc(25);
      chk("s6_no_pulse_after_reset", n_hit_seen + n_miss_seen - h0 - m0, 0);

      // Randomized traffic against the model
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 2) != 0) btn = 4'($urandom_range(0, 15));
         mole_mask   = 4'($urandom_range(0, 15));
         game_active = ($urandom_range(0, 11) != 0);
         cyc($urandom_range(1, 12));
      end
      game_active = 1'b1; btn = 4'b0000; cyc(30);
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
